// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_rr
// Description : N-port memory arbiter. Picks one requesting client (fixed
//               priority or round-robin), drives the single memory interface
//               until mem_ack or a bus timeout, then returns a one-cycle ack
//               (with err on timeout) to the served client.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            : system clock, all logic on rising edge
//   reset          : synchronous active-high reset
//   req_read       : per-port read request, held until ack
//   req_write      : per-port write request, held until ack (beats read)
//   req_addr       : packed per-port addresses, port i at [i*ADDR_W +: ADDR_W]
//   req_wdata      : packed per-port write data, same packing
//   ack            : one-cycle completion pulse to the served port
//   rdata          : read data, valid with ack for reads
//   err            : one-cycle pulse with ack when the access timed out
//   grant_id       : index of the port currently or last served
//   mem_read       : memory read strobe
//   mem_write      : memory write strobe
//   mem_ack        : memory completion
//   mem_addr       : memory address
//   mem_data_write : memory write data
//   mem_data_read  : memory read data, sampled with mem_ack
// ============================================================================
module mem_arbiter_rr #(
  parameter int NUM_PORTS      = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int RR_ENABLE      = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [DATA_W-1:0]           rdata,
  output logic                        err,
  output logic [$clog2(NUM_PORTS)-1:0] grant_id,
  output logic                        mem_read,
  output logic                        mem_write,
  input  logic                        mem_ack,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_data_write,
  input  logic [DATA_W-1:0]           mem_data_read
);

  localparam int IW = $clog2(NUM_PORTS);
  // A disabled timeout still needs a legal (1-bit) counter.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]           state, state_nxt;
  logic [CW-1:0]        tmo_cnt, tmo_cnt_nxt;
  logic [IW-1:0]        last_grant, last_grant_nxt;
  logic                 op_write, op_write_nxt;

  logic [NUM_PORTS-1:0] ack_nxt;
  logic [DATA_W-1:0]    rdata_nxt;
  logic                 err_nxt;
  logic [IW-1:0]        grant_id_nxt;
  logic                 mem_read_nxt, mem_write_nxt;
  logic [ADDR_W-1:0]    mem_addr_nxt;
  logic [DATA_W-1:0]    mem_data_write_nxt;

  logic [NUM_PORTS-1:0] eligible;
  logic                 any_req;
  logic [IW-1:0]        winner;
  logic [IW-1:0]        cand_idx;
  int                   cand;
  logic                 timeout_hit;

  assign eligible = req_read | req_write;

  // The counter holds the number of BUSY cycles already elapsed without
  // mem_ack, so the limit is reached on the edge closing the last allowed one.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Winner search: walk ports in priority order, first eligible wins.
  // Round-robin starts one past the last granted port.
  always_comb begin
    any_req  = 1'b0;
    winner   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand     = (RR_ENABLE != 0) ? ((int'(last_grant) + 1 + k) % NUM_PORTS) : k;
      cand_idx = IW'(cand);
      if (!any_req && eligible[cand_idx]) begin
        any_req = 1'b1;
        winner  = cand_idx;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      tmo_cnt        <= '0;
      last_grant     <= IW'(NUM_PORTS - 1);
      op_write       <= 1'b0;
      ack            <= '0;
      rdata          <= '0;
      err            <= 1'b0;
      grant_id       <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_addr       <= '0;
      mem_data_write <= '0;
    end else begin
      state          <= state_nxt;
      tmo_cnt        <= tmo_cnt_nxt;
      last_grant     <= last_grant_nxt;
      op_write       <= op_write_nxt;
      ack            <= ack_nxt;
      rdata          <= rdata_nxt;
      err            <= err_nxt;
      grant_id       <= grant_id_nxt;
      mem_read       <= mem_read_nxt;
      mem_write      <= mem_write_nxt;
      mem_addr       <= mem_addr_nxt;
      mem_data_write <= mem_data_write_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any_req) state_nxt = ST_BUSY;
      ST_BUSY: if (mem_ack || timeout_hit) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath next values. ack and err default low so they pulse
  // for exactly the DONE cycle.
  always_comb begin
    tmo_cnt_nxt        = tmo_cnt;
    last_grant_nxt     = last_grant;
    op_write_nxt       = op_write;
    ack_nxt            = '0;
    rdata_nxt          = rdata;
    err_nxt            = 1'b0;
    grant_id_nxt       = grant_id;
    mem_read_nxt       = mem_read;
    mem_write_nxt      = mem_write;
    mem_addr_nxt       = mem_addr;
    mem_data_write_nxt = mem_data_write;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          grant_id_nxt       = winner;
          last_grant_nxt     = winner;
          op_write_nxt       = req_write[winner];
          mem_write_nxt      = req_write[winner];
          mem_read_nxt       = ~req_write[winner];
          mem_addr_nxt       = req_addr[winner*ADDR_W +: ADDR_W];
          mem_data_write_nxt = req_wdata[winner*DATA_W +: DATA_W];
          tmo_cnt_nxt        = '0;
        end
      end
      ST_BUSY: begin
        // mem_ack takes precedence over a coincident timeout.
        if (mem_ack) begin
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
          if (!op_write) rdata_nxt = mem_data_read;
          ack_nxt       = NUM_PORTS'(1) << grant_id;
        end else if (timeout_hit) begin
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
          if (!op_write) rdata_nxt = '0;
          ack_nxt       = NUM_PORTS'(1) << grant_id;
          err_nxt       = 1'b1;
        end else begin
          tmo_cnt_nxt = tmo_cnt + CW'(1);
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
